// File: rtl/ssram_port_arbiter.sv
// ssram_port_arbiter: shares one SSRAM port between req0 (CPU) and req1 (DMA) with locked bursts
// Ports: clock/reset (sync, active-high); per requester X: reqX, lockX, weX, addressX, dataInX in,
// ackX (combinational), rvalidX/dataOutX out; SSRAM side: memWriteEnable, memAddress, memDataIn out,
// memDataOut in (1-cycle synchronous read).
// Build option: SSRAM_ARB_ROUND_ROBIN_EN selects alternating service on IDLE ties; default is req0 priority.
module ssram_port_arbiter #(
   parameter int bitwidth    = 32,
   parameter int nrOfEntries = 512,
   localparam int AW         = $clog2(nrOfEntries)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req0,
   input  logic                lock0,
   input  logic                we0,
   input  logic [AW-1:0]       address0,
   input  logic [bitwidth-1:0] dataIn0,
   output logic                ack0,
   output logic                rvalid0,
   output logic [bitwidth-1:0] dataOut0,
   input  logic                req1,
   input  logic                lock1,
   input  logic                we1,
   input  logic [AW-1:0]       address1,
   input  logic [bitwidth-1:0] dataIn1,
   output logic                ack1,
   output logic                rvalid1,
   output logic [bitwidth-1:0] dataOut1,
   output logic                memWriteEnable,
   output logic [AW-1:0]       memAddress,
   output logic [bitwidth-1:0] memDataIn,
   input  logic [bitwidth-1:0] memDataOut
);
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
   state_t state, state_nxt;
   logic last_grant, prio0, g0, g1;
   logic [AW-1:0] addr_q;
   logic [bitwidth-1:0] data_q;
`ifdef SSRAM_ARB_ROUND_ROBIN_EN
   assign prio0 = last_grant;
`else
   assign prio0 = 1'b1 | last_grant;
`endif
   always_comb begin
      g0 = state == LOCK0 ? req0 : (state == IDLE && req0 && (!req1 || prio0));
      g1 = state == LOCK1 ? req1 : (state == IDLE && req1 && !g0);
      state_nxt = g0 ? (lock0 ? LOCK0 : IDLE) : g1 ? (lock1 ? LOCK1 : IDLE) : state;
   end
   assign ack0           = g0;
   assign ack1           = g1;
   assign memWriteEnable = g0 ? we0 : g1 && we1;
   assign memAddress     = g0 ? address0 : g1 ? address1 : addr_q;
   assign memDataIn      = g0 ? dataIn0 : g1 ? dataIn1 : data_q;
   assign dataOut0       = memDataOut;
   assign dataOut1       = memDataOut;
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state   <= state_nxt;
         rvalid0 <= g0 && !we0;
         rvalid1 <= g1 && !we1;
         if (g0 || g1) begin
            last_grant <= g1;
            addr_q     <= memAddress;
            data_q     <= memDataIn;
         end
      end
   end
endmodule

// File: tb/tb_ssram_port_arbiter.sv
// tb_ssram_port_arbiter: directed scoreboard bench for ssram_port_arbiter with a behavioural SSRAM
module tb_ssram_port_arbiter;
   localparam int BW = 32;
   localparam int N  = 512;
   localparam int AW = 9;
   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset, req0, lock0, we0, req1, lock1, we1;
   logic [AW-1:0] address0, address1, memAddress;
   logic [BW-1:0] dataIn0, dataIn1, dataOut0, dataOut1, memDataIn, memDataOut;
   logic ack0, ack1, rvalid0, rvalid1, memWriteEnable;
   int checks = 0, errors = 0, cyc = 0, hold_exp = -1;
   logic [BW-1:0] mem [N];
   logic [BW-1:0] model [N];
   typedef struct {int due; logic [BW-1:0] d;} ent_t;
   ent_t q0[$], q1[$];

   ssram_port_arbiter #(.bitwidth(BW), .nrOfEntries(N)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .lock0(lock0), .we0(we0), .address0(address0), .dataIn0(dataIn0),
      .ack0(ack0), .rvalid0(rvalid0), .dataOut0(dataOut0),
      .req1(req1), .lock1(lock1), .we1(we1), .address1(address1), .dataIn1(dataIn1),
      .ack1(ack1), .rvalid1(rvalid1), .dataOut1(dataOut1),
      .memWriteEnable(memWriteEnable), .memAddress(memAddress), .memDataIn(memDataIn),
      .memDataOut(memDataOut));

   always @(posedge clock) begin
      if (memWriteEnable) mem[memAddress] <= memDataIn;
      memDataOut <= mem[memAddress];
      cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
         chk("rvalid0", rvalid0, 1);
         chk("dataOut0", dataOut0, q0[0].d);
         q0.delete(0);
      end else chk("rvalid0_quiet", rvalid0, 0);
      if (q1.size() > 0 && q1[0].due == cyc) begin
         chk("rvalid1", rvalid1, 1);
         chk("dataOut1", dataOut1, q1[0].d);
         q1.delete(0);
      end else chk("rvalid1_quiet", rvalid1, 0);
   end

   task automatic step(input logic rs, input logic r0, l0, w0, input logic [AW-1:0] a0,
                       input logic [BW-1:0] d0, input logic r1, l1, w1, input logic [AW-1:0] a1,
                       input logic [BW-1:0] d1, input logic e0, e1, input string tag);
      reset = rs; req0 = r0; lock0 = l0; we0 = w0; address0 = a0; dataIn0 = d0;
      req1 = r1; lock1 = l1; we1 = w1; address1 = a1; dataIn1 = d1;
      @(negedge clock);
      chk({tag, "_ack0"}, ack0, e0);
      chk({tag, "_ack1"}, ack1, e1);
      if (e0) begin
         chk({tag, "_we"}, memWriteEnable, w0);
         chk({tag, "_addr"}, memAddress, a0);
         if (w0) begin
            chk({tag, "_wdata"}, memDataIn, d0);
            model[a0] = d0;
         end else if (!rs) q0.push_back('{cyc + 1, model[a0]});
      end
      if (e1) begin
         chk({tag, "_we"}, memWriteEnable, w1);
         chk({tag, "_addr"}, memAddress, a1);
         if (w1) begin
            chk({tag, "_wdata"}, memDataIn, d1);
            model[a1] = d1;
         end else if (!rs) q1.push_back('{cyc + 1, model[a1]});
      end
      if (!e0 && !e1) begin
         chk({tag, "_mwe_idle"}, memWriteEnable, 0);
         if (hold_exp >= 0) chk({tag, "_addr_hold"}, memAddress, hold_exp);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(0, 0,0,0,0,0, 0,0,0,0,0, 0,0, "nop");
   endtask

   initial begin
      logic e;
      for (int i = 0; i < N; i++) begin
         mem[i] = 32'h1000_0000 + i;
         model[i] = 32'h1000_0000 + i;
      end
      mem[5] = 32'hA5A5_A5A5;
      model[5] = 32'hA5A5_A5A5;
      step(1, 0,0,0,0,0, 0,0,0,0,0, 0,0, "rst");
      step(1, 0,0,0,0,0, 0,0,0,0,0, 0,0, "rst");
      step(0, 0,0,0,0,0, 0,0,0,0,0, 0,0, "rst_idle");
      step(0, 1,0,0,5,0, 0,0,0,0,0, 1,0, "t1_read5");
      nop(2);
      step(0, 0,0,0,0,0, 1,0,0,6,0, 0,1, "prime_r1");
      for (int i = 0; i < 4; i++) begin
`ifdef SSRAM_ARB_ROUND_ROBIN_EN
         e = (i % 2 == 0);
`else
         e = 1'b1;
`endif
         step(0, 1,0,0,1,0, 1,0,0,2,0, e, !e, "t2_tie");
      end
      nop(1);
      step(0, 0,0,0,0,0, 1,1,1,10,1, 0,1, "t3_lockw10");
      step(0, 1,0,0,0,0, 1,1,1,11,2, 0,1, "t3_lockw11");
      step(0, 1,0,0,0,0, 1,1,1,12,3, 0,1, "t3_lockw12");
      step(0, 1,0,0,0,0, 1,0,1,13,4, 0,1, "t3_unlockw13");
      step(0, 1,0,0,0,0, 0,0,0,0,0, 1,0, "t3_r0_after");
      step(0, 1,0,0,10,0, 0,0,0,0,0, 1,0, "t3_rb10");
      step(0, 1,0,0,11,0, 0,0,0,0,0, 1,0, "t3_rb11");
      step(0, 1,0,0,12,0, 0,0,0,0,0, 1,0, "t3_rb12");
      step(0, 1,0,1,7,32'hDEADBEEF, 0,0,0,0,0, 1,0, "t4_w7");
      step(0, 1,0,0,7,0, 0,0,0,0,0, 1,0, "t4_r7");
      nop(1);
      step(1, 0,0,0,0,0, 1,0,0,3,0, 0,1, "t5_rst_read");
      step(0, 1,0,0,1,0, 1,0,0,2,0, 1,0, "t5_first_tie");
`ifdef SSRAM_ARB_ROUND_ROBIN_EN
      step(0, 1,0,0,1,0, 1,0,0,2,0, 0,1, "t5_second_tie");
`else
      step(0, 1,0,0,1,0, 1,0,0,2,0, 1,0, "t5_second_tie");
`endif
      nop(1);
      step(0, 1,1,1,20,32'h55, 0,0,0,0,0, 1,0, "t6_lock0_w20");
      hold_exp = 20;
      for (int i = 0; i < 3; i++) step(0, 0,0,0,0,0, 1,0,0,4,0, 0,0, "t6_stall");
      hold_exp = -1;
      step(0, 1,0,0,20,0, 1,0,0,4,0, 1,0, "t6_unlock_r20");
      step(0, 0,0,0,0,0, 1,0,0,4,0, 0,1, "t6_idle_r1");
      nop(2);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
